// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Parameter legality check and the mode-dependent local encode live here.
package prio_enc_pkg;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    // Widest slice the local encoder helper can handle.
    localparam int unsigned ENC_MAX_W = 32'd64;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned slice);
        return is_pow2(width) && (width >= 32'd4) &&
               is_pow2(slice) && (slice >= 32'd2) && (slice <= width / 32'd2) &&
               (slice <= ENC_MAX_W) && ((width % slice) == 32'd0);
    endfunction

    // Index of the highest (MSB_FIRST) or lowest (LSB_FIRST) set bit among the low n bits.
    function automatic int unsigned local_encode(input logic [ENC_MAX_W-1:0] bits,
                                                 input int unsigned n,
                                                 input logic mode);
        int unsigned idx;
        bit found;
        idx   = 32'd0;
        found = 1'b0;
        for (int unsigned i = 32'd0; i < ENC_MAX_W; i++) begin
            if ((i < n) && bits[i[5:0]] && ((mode == MSB_FIRST) || !found)) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_slice_enc.sv
// Combinational SLICE-bit priority encoder: hit flag plus local winning index.
module prio_slice_enc
    import prio_enc_pkg::*;
#(
    parameter  int unsigned SLICE  = 2,
    localparam int unsigned LIDX_W = $clog2(SLICE)
) (
    input  logic [SLICE-1:0]  bits,
    input  logic              msb_first,
    output logic              hit,
    output logic [LIDX_W-1:0] idx
);

    assign hit = |bits;
    assign idx = LIDX_W'(local_encode(ENC_MAX_W'(bits), SLICE, msb_first));

endmodule

// File: rtl/prio_encoder_pipe.sv
// Two-stage (slice / combine) priority encoder with valid/ready on both sides.
// Optional out_onehot port enabled by defining PRIO_ENC_ONEHOT_EN.
module prio_encoder_pipe
    import prio_enc_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    parameter  int unsigned SLICE  = 2,
    localparam int unsigned IDX_W  = $clog2(WIDTH),
    localparam int unsigned NSLICE = WIDTH / SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_hit
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] out_onehot
`endif
);

    localparam int unsigned LIDX_W = $clog2(SLICE);
    localparam int unsigned SEL_W  = $clog2(NSLICE);

    if (!params_ok(WIDTH, SLICE)) begin : g_param_err
        $error("prio_encoder_pipe: illegal WIDTH/SLICE combination");
    end

    logic [NSLICE-1:0]             slice_hit_s;
    logic [NSLICE-1:0][LIDX_W-1:0] slice_idx_s;

    logic                          s1_valid_d, s1_valid_q;
    logic [NSLICE-1:0]             s1_hit_d, s1_hit_q;
    logic [NSLICE-1:0][LIDX_W-1:0] s1_idx_d, s1_idx_q;
    logic                          s1_mode_d, s1_mode_q;

    logic                          out_valid_d, out_valid_q;
    logic [IDX_W-1:0]              out_index_d, out_index_q;
    logic                          out_hit_d, out_hit_q;
    logic [IDX_W-1:0]              last_index_d, last_index_q;

    logic                          advance_s;
    logic                          in_fire_s;
    logic                          win_found_s;
    logic [SEL_W-1:0]              win_sel_s;
    logic [IDX_W-1:0]              win_index_s;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        prio_slice_enc #(.SLICE(SLICE)) u_enc (
            .bits      (in_data[k*SLICE +: SLICE]),
            .msb_first (in_msb_first),
            .hit       (slice_hit_s[k]),
            .idx       (slice_idx_s[k])
        );
    end

    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = !rst && (!s1_valid_q || !out_valid_q || out_ready);
    assign in_fire_s = in_valid && in_ready;

    // Stage 1 may also refill an empty slot while stage 2 is stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_hit_d   = s1_hit_q;
        s1_idx_d   = s1_idx_q;
        s1_mode_d  = s1_mode_q;
        if (!s1_valid_q || advance_s) begin
            s1_valid_d = in_fire_s;
            s1_hit_d   = slice_hit_s;
            s1_idx_d   = slice_idx_s;
            s1_mode_d  = in_msb_first;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        win_found_s = 1'b0;
        win_sel_s   = {SEL_W{1'b0}};
        for (int k = 0; k < NSLICE; k++) begin
            if (s1_hit_q[SEL_W'(k)] && ((s1_mode_q == MSB_FIRST) || !win_found_s)) begin
                win_found_s = 1'b1;
                win_sel_s   = SEL_W'(k);
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_index_s = {win_sel_s, s1_idx_q[win_sel_s]};
    end

    // A miss reports the most recent hit index; only hits refresh it.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_hit_d    = out_hit_q;
        last_index_d = last_index_q;
        if (advance_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_hit_d   = win_found_s;
                out_index_d = win_found_s ? win_index_s : last_index_q;
                if (win_found_s) begin
                    last_index_d = win_index_s;
                end else begin
                    last_index_d = last_index_q;
                end
            end else begin
                out_hit_d = out_hit_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= '0;
            s1_idx_q     <= '0;
            s1_mode_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_hit_q    <= 1'b0;
            last_index_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_idx_q     <= s1_idx_d;
            s1_mode_q    <= s1_mode_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_hit_q    <= out_hit_d;
            last_index_q <= last_index_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_hit   = out_hit_q;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [WIDTH-1:0] out_onehot_d, out_onehot_q;

    // One-hot mirror of out_index, cleared on a miss.
    always_comb begin
        out_onehot_d = out_onehot_q;
        if (advance_s && s1_valid_q) begin
            out_onehot_d = win_found_s ? ({{(WIDTH-1){1'b0}}, 1'b1} << win_index_s)
                                       : {WIDTH{1'b0}};
        end else begin
            out_onehot_d = out_onehot_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_onehot_q <= '0;
        end else begin
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_onehot = out_onehot_q;
`else
`endif

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Self-checking bench for prio_encoder_pipe (16/2 instance plus a 32/4 instance).
// Checks out_onehot as well when PRIO_ENC_ONEHOT_EN is defined.
module tb_prio_encoder_pipe;

    localparam int W  = 16;
    localparam int W2 = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_msb_first = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_index;
    logic        out_hit;

    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] in_data32 = 32'h0;
    logic        in_msb_first32 = 1'b0;
    logic        out_valid32;
    logic [4:0]  out_index32;
    logic        out_hit32;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [15:0] out_onehot;
    logic [31:0] out_onehot32;
`endif

    always #5 clk = ~clk;

    prio_encoder_pipe #(.WIDTH(16), .SLICE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_hit(out_hit)
`ifdef PRIO_ENC_ONEHOT_EN
        , .out_onehot(out_onehot)
`endif
    );

    prio_encoder_pipe #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data32), .in_msb_first(in_msb_first32), .out_valid(out_valid32),
        .out_ready(1'b1), .out_index(out_index32), .out_hit(out_hit32)
`ifdef PRIO_ENC_ONEHOT_EN
        , .out_onehot(out_onehot32)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        mode;
    } stim_t;

    stim_t stim_q[$];
    int    exp_idx[$];
    bit    exp_hit[$];
    int    acc_cyc[$];
    int    got_idx[$];
    bit    got_hit[$];
    int    got_cyc[$];
    int    model_last = 0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    // Reference: scan the vector from the winning end; misses repeat the last hit.
    function automatic void model_push(input logic [15:0] d, input logic m);
        int idx;
        bit hit;
        idx = 0;
        hit = 1'b0;
        if (m) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (d[i[3:0]]) begin idx = i; hit = 1'b1; break; end
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (d[i[3:0]]) begin idx = i; hit = 1'b1; break; end
            end
        end
        if (!hit) idx = model_last;
        else model_last = idx;
        exp_idx.push_back(idx);
        exp_hit.push_back(hit);
        acc_cyc.push_back(cyc);
    endfunction

    function automatic void clear_q();
        stim_q.delete(); exp_idx.delete(); exp_hit.delete(); acc_cyc.delete();
        got_idx.delete(); got_hit.delete(); got_cyc.delete();
    endfunction

    task automatic tick();
        in_valid = (stim_q.size() != 0);
        if (in_valid) begin
            in_data      = stim_q[0].data;
            in_msb_first = stim_q[0].mode;
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
            model_push(stim_q[0].data, stim_q[0].mode);
            void'(stim_q.pop_front());
        end
        if (out_valid && out_ready) begin
            got_idx.push_back(int'(out_index));
            got_hit.push_back(out_hit);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || got_idx.size() < exp_idx.size()) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got=%0d results, required=%0d", got_idx.size(), exp_idx.size());
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.data = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom & $urandom);
        s.mode = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got=%b required=0", in_ready); end
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got=%b required=0", out_valid); end
        checks++;
        if (out_hit !== 1'b0 || out_index !== 4'd0) begin
            failures++; $display("FAIL reset_out: got hit=%b idx=%0d required hit=0 idx=0", out_hit, out_index);
        end
        clear_q(); model_last = 0;
        stim_q.push_back('{16'h0000, 1'($urandom_range(0, 1))});
        drain(20);
        checks++;
        if (got_idx.size() != 1 || got_hit[0] !== 1'b0 || got_idx[0] != 0) begin
            failures++; $display("FAIL reset_first_miss: got n=%0d required one miss at index 0", got_idx.size());
        end else begin
            checks++;
            if (got_cyc[0] - acc_cyc[0] != 2) begin
                failures++; $display("FAIL latency: got=%0d required=2", got_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_modes_back_to_back();
        clear_q();
        out_ready = 1'b1;
        stim_q.push_back('{16'h8421, 1'b1});
        stim_q.push_back('{16'h8421, 1'b0});
        drain(20);
        checks++;
        if (got_idx.size() != 2) begin
            failures++; $display("FAIL b2b_count: got=%0d required=2", got_idx.size());
        end else begin
            checks++;
            if (got_idx[0] != 15 || got_hit[0] !== 1'b1) begin
                failures++; $display("FAIL msb_8421: got idx=%0d hit=%b required idx=15 hit=1", got_idx[0], got_hit[0]);
            end
            checks++;
            if (got_idx[1] != 0 || got_hit[1] !== 1'b1) begin
                failures++; $display("FAIL lsb_8421: got idx=%0d hit=%b required idx=0 hit=1", got_idx[1], got_hit[1]);
            end
            checks++;
            if (got_cyc[1] - got_cyc[0] != 1) begin
                failures++; $display("FAIL b2b_spacing: got=%0d required=1", got_cyc[1] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_hold_last();
        int ref_idx[3] = '{5, 5, 8};
        bit ref_hit[3] = '{1'b1, 1'b0, 1'b1};
        clear_q();
        out_ready = 1'b1;
        stim_q.push_back('{16'h0030, 1'b1});
        stim_q.push_back('{16'h0000, 1'($urandom_range(0, 1))});
        stim_q.push_back('{16'h0100, 1'($urandom_range(0, 1))});
        drain(20);
        checks++;
        if (got_idx.size() != 3) begin
            failures++; $display("FAIL hold_count: got=%0d required=3", got_idx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_idx[i] != ref_idx[i] || got_hit[i] !== ref_hit[i]) begin
                    failures++;
                    $display("FAIL hold_%0d: got idx=%0d hit=%b required idx=%0d hit=%b",
                             i, got_idx[i], got_hit[i], ref_idx[i], ref_hit[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] si;
        logic       sh;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) stim_q.push_back(rand_stim());
        for (int i = 0; i < 3; i++) tick();
        si = out_index;
        sh = out_hit;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_index !== si || out_hit !== sh) begin
                failures++;
                $display("FAIL stall_hold_%0d: got v=%b idx=%0d hit=%b required v=1 idx=%0d hit=%b",
                         i, out_valid, out_index, out_hit, si, sh);
            end
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_%0d: got=%b required=0", i, in_ready); end
        end
        out_ready = 1'b1;
        drain(60);
        checks++;
        if (got_idx.size() != 8 || exp_idx.size() != 8) begin
            failures++; $display("FAIL stall_count: got=%0d accepted=%0d required=8", got_idx.size(), exp_idx.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_idx[i] != exp_idx[i] || got_hit[i] !== exp_hit[i]) begin
                    failures++;
                    $display("FAIL stall_result_%0d: got idx=%0d hit=%b required idx=%0d hit=%b",
                             i, got_idx[i], got_hit[i], exp_idx[i], exp_hit[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        clear_q();
        for (int i = 0; i < 40; i++) stim_q.push_back(rand_stim());
        n = 0;
        while (stim_q.size() != 0 && n < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        drain(40);
        checks++;
        if (got_idx.size() != 40) begin
            failures++; $display("FAIL random_count: got=%0d required=40", got_idx.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (got_idx[i] != exp_idx[i] || got_hit[i] !== exp_hit[i]) begin
                    failures++;
                    $display("FAIL random_%0d: got idx=%0d hit=%b required idx=%0d hit=%b",
                             i, got_idx[i], got_hit[i], exp_idx[i], exp_hit[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b0;
        stim_q.push_back('{16'h0100, 1'b1});
        stim_q.push_back('{16'h0200, 1'b1});
        tick();
        tick();
        stim_q.delete();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midflight_out_valid: got=%b required=0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL midflight_in_ready: got=%b required=0", in_ready); end
        rst = 1'b0;
        clear_q(); model_last = 0;
        out_ready = 1'b1;
        stim_q.push_back('{16'h0000, 1'($urandom_range(0, 1))});
        drain(20);
        checks++;
        if (got_idx.size() != 1 || got_idx[0] != 0 || got_hit[0] !== 1'b0) begin
            failures++; $display("FAIL midflight_miss: got n=%0d required one miss at index 0", got_idx.size());
        end
    endtask

    task automatic test_wide();
        logic [31:0] vec[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        logic        mode[3] = '{1'b1, 1'b0, 1'b1};
        bit          hit[3]  = '{1'b1, 1'b1, 1'b0};
        int          n;
        for (int c = 0; c < 3; c++) begin
            in_valid32     = 1'b1;
            in_data32      = vec[c];
            in_msb_first32 = mode[c];
            @(negedge clk);
            checks++;
            if (in_ready32 !== 1'b1) begin failures++; $display("FAIL wide_in_ready_%0d: got=%b required=1", c, in_ready32); end
            @(posedge clk);
            #1;
            in_valid32 = 1'b0;
            n = 0;
            @(negedge clk);
            while (!out_valid32 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!out_valid32) begin
                failures++; $display("FAIL wide_timeout_%0d: got no result, required one", c);
            end else if (out_index32 !== 5'd16 || out_hit32 !== hit[c]) begin
                failures++;
                $display("FAIL wide_%0d: got idx=%0d hit=%b required idx=16 hit=%b", c, out_index32, out_hit32, hit[c]);
            end
`ifdef PRIO_ENC_ONEHOT_EN
            checks++;
            if (out_onehot32 !== (hit[c] ? 32'h0001_0000 : 32'h0)) begin
                failures++; $display("FAIL wide_onehot_%0d: got=%h", c, out_onehot32);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_modes_back_to_back();
        test_hold_last();
        test_stall();
        test_random();
        test_reset_midflight();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
